mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 179 +++++++++++++++++
 tb/tb_mem_access.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access -- MEM pipeline stage with a registered single-beat bus master.
//
// Loads (LB/LW) and stores (SB/SW) run as IDLE -> BUS -> DONE. The stage
// stalls the front of the pipeline while a bus access is in flight and
// presents the load result to WB in the DONE cycle. A misaligned word
// access, or a bus that does not ack within TIMEOUT cycles, is reported
// through a one-cycle addr_err_o pulse.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   aluop_i             operation from EX (memory ops decoded below)
//   mem_addr_i          effective byte address
//   mem_data_i          store data
//   waddr_i/we_i/wdata_i  EX result and destination register
//   waddr_o/we_o/wdata_o  result to WB
//   stallreq_o          holds IF/ID/EX and this stage's input register
//   addr_err_o          misaligned word access or bus timeout pulse
//   bus_req_o/bus_we_o/bus_be_o/bus_addr_o/bus_wdata_o  registered request
//   bus_ack_i/bus_rdata_i  completion and read data (valid in ack cycle)

`ifndef MEM_ACCESS_DEFINES
`define MEM_ACCESS_DEFINES
`define AluOpBus   7:0
`define RegAddrBus 4:0
`define NOPRegAddr 5'b00000
`define MEM_LB_OP  8'b11100000
`define MEM_LW_OP  8'b11100011
`define MEM_SB_OP  8'b11101000
`define MEM_SW_OP  8'b11101011
`endif

module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_data_i,
  input  logic [`RegAddrBus] waddr_i,
  input  logic               we_i,
  input  logic [31:0]        wdata_i,
  output logic [`RegAddrBus] waddr_o,
  output logic               we_o,
  output logic [31:0]        wdata_o,
  output logic               stallreq_o,
  output logic               addr_err_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [3:0]         bus_be_o,
  output logic [31:0]        bus_addr_o,
  output logic [31:0]        bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic [31:0]        bus_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The counter value seen in the last allowed BUS cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic        abort_q;
  logic        is_load_q;
  logic        is_byte_q;
  logic [1:0]  lane_q;

  // Operation decode.
  logic is_lb, is_lw, is_sb, is_sw, is_mem, is_word, misaligned, start;
  assign is_lb      = (aluop_i == `MEM_LB_OP);
  assign is_lw      = (aluop_i == `MEM_LW_OP);
  assign is_sb      = (aluop_i == `MEM_SB_OP);
  assign is_sw      = (aluop_i == `MEM_SW_OP);
  assign is_mem     = is_lb | is_lw | is_sb | is_sw;
  assign is_word    = is_lw | is_sw;
  assign misaligned = is_word && (mem_addr_i[1:0] != 2'b00);
  assign start      = is_mem && !misaligned;

  // Little-endian byte lane of the captured word for LB.
  logic [7:0]  load_byte;
  logic [31:0] load_byte_sext;
  assign load_byte      = rdata_q[8*lane_q +: 8];
  assign load_byte_sext = {{24{load_byte[7]}}, load_byte};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      rdata_q     <= '0;
      abort_q     <= 1'b0;
      is_load_q   <= 1'b0;
      is_byte_q   <= 1'b0;
      lane_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_sb | is_sw;
            bus_be_o    <= is_word ? 4'b1111 : (4'b0001 << mem_addr_i[1:0]);
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_wdata_o <= is_sw ? mem_data_i :
                           is_sb ? {4{mem_data_i[7:0]}} : 32'h0;
            wait_cnt    <= '0;
            abort_q     <= 1'b0;
            is_load_q   <= is_lb | is_lw;
            is_byte_q   <= is_lb | is_sb;
            lane_q      <= mem_addr_i[1:0];
            state       <= BUS;
          end
        end
        BUS: begin
          // An ack in the last allowed cycle still completes normally.
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            rdata_q   <= bus_rdata_i;
            state     <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_req_o <= 1'b0;
            abort_q   <= 1'b1;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    waddr_o    = waddr_i;
    we_o       = 1'b0;
    wdata_o    = 32'h0;
    stallreq_o = 1'b0;
    addr_err_o = 1'b0;
    if (!rst) begin
      waddr_o = `NOPRegAddr;
    end else begin
      case (state)
        IDLE: begin
          if (misaligned) begin
            addr_err_o = 1'b1;
          end else if (start) begin
            stallreq_o = 1'b1;
          end else begin
            we_o    = we_i;
            wdata_o = wdata_i;
          end
        end
        BUS: stallreq_o = 1'b1;
        DONE: begin
          if (abort_q) begin
            addr_err_o = 1'b1;
          end else if (is_load_q) begin
            we_o    = we_i;
            wdata_o = is_byte_q ? load_byte_sext : rdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- scoreboard bench for mem_access (TIMEOUT = 4).
// Stimulus pushes expected WB results and bus requests into queues; a
// WB monitor and a bus monitor pop and compare as the DUT presents them.

`ifndef MEM_ACCESS_DEFINES
`define MEM_ACCESS_DEFINES
`define AluOpBus   7:0
`define RegAddrBus 4:0
`define NOPRegAddr 5'b00000
`define MEM_LB_OP  8'b11100000
`define MEM_LW_OP  8'b11100011
`define MEM_SB_OP  8'b11101000
`define MEM_SW_OP  8'b11101011
`endif

module tb_mem_access;

  localparam logic [7:0] NOP_OP = 8'h21;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [31:0] mem_addr_i = '0, mem_data_i = '0, wdata_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_o;
  logic        we_o, stallreq_o, addr_err_o;
  logic [31:0] wdata_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        ack_r = 1'b0, stray_ack = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i;
  assign bus_ack_i = ack_r | stray_ack;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .addr_err_o(addr_err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct {
    string name; logic we; logic [31:0] wdata; logic [4:0] waddr;
    logic err; bit chk_wdata; int stalls;
  } res_t;
  typedef struct {
    string name; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
  } bus_t;
  typedef struct { int waits; bit noack; logic [31:0] rdata; } plan_t;

  res_t  res_q[$];
  bus_t  bus_q[$];
  plan_t plan_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- WB-side monitor ----------------
  int   stall_cnt = 0;
  res_t r;
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (stallreq_o) begin
        stall_cnt++;
      end else begin
        if (res_q.size() == 0) begin
          check("wb_unexpected_result", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check({r.name, ".stalls"}, stall_cnt, r.stalls);
          check({r.name, ".we"},     {31'd0, we_o}, {31'd0, r.we});
          check({r.name, ".err"},    {31'd0, addr_err_o}, {31'd0, r.err});
          check({r.name, ".waddr"},  {27'd0, waddr_o}, {27'd0, r.waddr});
          if (r.chk_wdata) check({r.name, ".wdata"}, wdata_o, r.wdata);
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- bus-side monitor ----------------
  logic bus_prev = 1'b0;
  bit   bus_have = 1'b0;
  bus_t cur;
  always @(negedge clk) begin
    if (bus_req_o) begin
      if (!bus_prev) begin
        bus_have = (bus_q.size() != 0);
        if (bus_have) cur = bus_q.pop_front();
        else check("bus_unexpected_request", 32'd1, 32'd0);
      end
      if (bus_have) begin
        check({cur.name, ".bus_we"},    {31'd0, bus_we_o}, {31'd0, cur.we});
        check({cur.name, ".bus_be"},    {28'd0, bus_be_o}, {28'd0, cur.be});
        check({cur.name, ".bus_addr"},  bus_addr_o, cur.addr);
        check({cur.name, ".bus_wdata"}, bus_wdata_o, cur.wdata);
      end
    end
    bus_prev = bus_req_o;
  end

  // ---------------- bus responder ----------------
  bit    resp_active = 1'b0;
  int    resp_left   = 0;
  plan_t p;
  always @(negedge clk) begin
    if (!bus_req_o) begin
      ack_r       = 1'b0;
      resp_active = 1'b0;
    end else begin
      if (!resp_active) begin
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else p = '{waits: 0, noack: 1'b1, rdata: 32'h0};
        resp_active = 1'b1;
        resp_left   = p.waits;
      end
      if (!p.noack && resp_left == 0) begin
        ack_r       = 1'b1;
        bus_rdata_i = p.rdata;
      end else begin
        ack_r = 1'b0;
        resp_left--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_res(string name, logic we, logic [31:0] wd, logic [4:0] wa,
                         logic err, bit chk, int stalls);
    res_q.push_back('{name: name, we: we, wdata: wd, waddr: wa, err: err,
                      chk_wdata: chk, stalls: stalls});
  endtask

  task automatic exp_bus(string name, logic we, logic [3:0] be,
                         logic [31:0] addr, logic [31:0] wd);
    bus_q.push_back('{name: name, we: we, be: be, addr: addr, wdata: wd});
  endtask

  task automatic plan(int waits, bit noack, logic [31:0] rdata);
    plan_q.push_back('{waits: waits, noack: noack, rdata: rdata});
  endtask

  // Presents one instruction and holds it until the stage stops stalling.
  task automatic drive(logic [7:0] op, logic [31:0] addr, logic [31:0] data,
                       logic [4:0] wa, logic we, logic [31:0] wd);
    int n;
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; mem_data_i = data;
    waddr_i = wa; we_i = we; wdata_i = wd;
    mon_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (stallreq_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (stallreq_o) check("stall_release_bound", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset with a live LW on the inputs: outputs must be forced quiet.
    rst = 1'b0; aluop_i = `MEM_LW_OP; mem_addr_i = 32'h10;
    waddr_i = 5'd5; we_i = 1'b1; wdata_i = 32'h0000FFFF;
    @(negedge clk);
    check("rst.waddr",    {27'd0, waddr_o}, 32'd0);
    check("rst.we",       {31'd0, we_o}, 32'd0);
    check("rst.wdata",    wdata_o, 32'd0);
    check("rst.stall",    {31'd0, stallreq_o}, 32'd0);
    check("rst.err",      {31'd0, addr_err_o}, 32'd0);
    check("rst.bus_req",  {31'd0, bus_req_o}, 32'd0);
    check("rst.bus_fields", {bus_we_o, bus_be_o, bus_addr_o[26:0]} | bus_wdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; aluop_i = NOP_OP; we_i = 1'b0;

    exp_res("alu_pass", 1'b1, 32'h12345678, 5'd3, 1'b0, 1'b1, 0);
    drive(NOP_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h12345678);

    exp_res("lw_fast", 1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1, 2);
    exp_bus("lw_fast", 1'b0, 4'b1111, 32'h80000010, 32'h0);
    plan(0, 1'b0, 32'hDEADBEEF);
    drive(`MEM_LW_OP, 32'h80000010, 32'h11111111, 5'd5, 1'b1, 32'h0);

    // Ack in the last cycle before the timeout limit must win.
    exp_res("lb_lane3", 1'b1, 32'hFFFFFF80, 5'd6, 1'b0, 1'b1, 5);
    exp_bus("lb_lane3", 1'b0, 4'b1000, 32'h80000010, 32'h0);
    plan(3, 1'b0, 32'h80FF1234);
    drive(`MEM_LB_OP, 32'h80000013, 32'h0, 5'd6, 1'b1, 32'h0);

    exp_res("lb_lane0", 1'b1, 32'h0000007F, 5'd7, 1'b0, 1'b1, 3);
    exp_bus("lb_lane0", 1'b0, 4'b0001, 32'h00000100, 32'h0);
    plan(1, 1'b0, 32'h8080807F);
    drive(`MEM_LB_OP, 32'h00000100, 32'h0, 5'd7, 1'b1, 32'h0);

    exp_res("sb", 1'b0, 32'h0, 5'd8, 1'b0, 1'b1, 2);
    exp_bus("sb", 1'b1, 4'b0010, 32'h00000000, 32'hA5A5A5A5);
    plan(0, 1'b0, 32'h0);
    drive(`MEM_SB_OP, 32'h00000001, 32'h123456A5, 5'd8, 1'b1, 32'h0);

    exp_res("sw_misaligned", 1'b0, 32'h0, 5'd9, 1'b1, 1'b0, 0);
    drive(`MEM_SW_OP, 32'h00000006, 32'hFFFFFFFF, 5'd9, 1'b1, 32'h0);

    exp_res("alu_after_err", 1'b1, 32'h00C0FFEE, 5'd10, 1'b0, 1'b1, 0);
    drive(NOP_OP, 32'h0, 32'h0, 5'd10, 1'b1, 32'h00C0FFEE);

    exp_res("sw", 1'b0, 32'h0, 5'd11, 1'b0, 1'b1, 4);
    exp_bus("sw", 1'b1, 4'b1111, 32'h00000008, 32'hCAFEF00D);
    plan(2, 1'b0, 32'h0);
    drive(`MEM_SW_OP, 32'h00000008, 32'hCAFEF00D, 5'd11, 1'b1, 32'h0);

    exp_res("lw_timeout", 1'b0, 32'h0, 5'd12, 1'b1, 1'b1, 5);
    exp_bus("lw_timeout", 1'b0, 4'b1111, 32'h00000020, 32'h0);
    plan(0, 1'b1, 32'h0);
    drive(`MEM_LW_OP, 32'h00000020, 32'h0, 5'd12, 1'b1, 32'h0);

    exp_res("lw_misaligned", 1'b0, 32'h0, 5'd13, 1'b1, 1'b0, 0);
    drive(`MEM_LW_OP, 32'h00000081, 32'h0, 5'd13, 1'b1, 32'h0);

    exp_res("alu_tail", 1'b0, 32'h00000042, 5'd14, 1'b0, 1'b1, 0);
    drive(NOP_OP, 32'h0, 32'h0, 5'd14, 1'b0, 32'h00000042);

    // Reset while in BUS, then a stray ack once back in IDLE.
    @(posedge clk); #1;
    mon_en = 1'b0;
    aluop_i = `MEM_LW_OP; mem_addr_i = 32'h40; waddr_i = 5'd7; we_i = 1'b1;
    exp_bus("lw_reset", 1'b0, 4'b1111, 32'h00000040, 32'h0);
    plan(0, 1'b1, 32'h0);
    @(negedge clk);
    check("rstbus.stall_idle", {31'd0, stallreq_o}, 32'd1);
    @(negedge clk);
    check("rstbus.in_bus", {31'd0, bus_req_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstbus.stall_low",  {31'd0, stallreq_o}, 32'd0);
    check("rstbus.we_low",     {31'd0, we_o}, 32'd0);
    check("rstbus.waddr_nop",  {27'd0, waddr_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; stray_ack = 1'b1; bus_rdata_i = 32'h5A5A5A5A;
    aluop_i = NOP_OP; waddr_i = 5'd9; we_i = 1'b1; wdata_i = 32'h55;
    @(negedge clk);
    check("rstbus.req_cleared", {31'd0, bus_req_o}, 32'd0);
    check("rstbus.bus_addr_cleared", bus_addr_o, 32'd0);
    check("rstbus.idle_pass_we",    {31'd0, we_o}, 32'd1);
    check("rstbus.idle_pass_wdata", wdata_o, 32'h55);
    @(posedge clk); #1;
    stray_ack = 1'b0; we_i = 1'b0;
    @(negedge clk);
    check("rstbus.ack_ignored_req",   {31'd0, bus_req_o}, 32'd0);
    check("rstbus.ack_ignored_stall", {31'd0, stallreq_o}, 32'd0);
    check("rstbus.no_wb_write",       {31'd0, we_o}, 32'd0);

    check("wb_queue_drained",  res_q.size(), 32'd0);
    check("bus_queue_drained", bus_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
